// File: rtl/csr_file.sv
// Machine-mode CSR file: combinational EX read with WB bypass, WB commit,
// trap/mret sequencing, 64-bit cycle/instret counters and interrupt pending.
module csr_file #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] MTVEC_RESET  = XLEN'(40),
    parameter bit              MTVEC_VEC_EN = 1'b1,
    parameter bit              CNT_EN       = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [11:0]     ex_csr_idx_i,
    output logic [XLEN-1:0] ex_csr_rdata_o,
    output logic            ex_csr_ill_o,
    input  logic            wb_csr_wen_i,
    input  logic [11:0]     wb_csr_idx_i,
    input  logic [XLEN-1:0] wb_csr_wdata_i,
    input  logic            trap_valid_i,
    input  logic            trap_is_irq_i,
    input  logic [4:0]      trap_cause_i,
    input  logic [XLEN-1:0] trap_pc_i,
    input  logic [XLEN-1:0] trap_tval_i,
    input  logic            mret_i,
    input  logic            instret_i,
    input  logic            irq_sw_i,
    input  logic            irq_timer_i,
    input  logic            irq_ext_i,
    output logic [XLEN-1:0] trap_target_o,
    output logic [XLEN-1:0] mepc_rdata_o,
    output logic            irq_pending_o
);

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MTVAL     = 12'h343;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;

    // Counter bits covered by the low CSR; on XLEN=64 that is the whole counter.
    localparam logic [63:0] LO_MASK = (XLEN == 64) ? 64'hFFFF_FFFF_FFFF_FFFF
                                                   : 64'h0000_0000_FFFF_FFFF;

    logic            st_mie, st_mpie;
    logic [2:0]      mie_q, mip_q;
    logic [XLEN-1:0] mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
    logic [63:0]     mcycle_q, minstret_q, mcycle_d, minstret_d, wdata64;
    logic [XLEN-1:0] mstatus_view, mie_view, mip_view, trap_mcause, base;
    logic [XLEN-1:0] wb_val;
    logic            wb_ok, wr;
    logic [1:0]      mtvec_mode;

    always_comb begin
        mstatus_view        = '0;
        mstatus_view[12:11] = 2'b11;
        mstatus_view[7]     = st_mpie;
        mstatus_view[3]     = st_mie;
        mie_view            = '0;
        mie_view[3]         = mie_q[0];
        mie_view[7]         = mie_q[1];
        mie_view[11]        = mie_q[2];
        mip_view            = '0;
        mip_view[3]         = mip_q[0];
        mip_view[7]         = mip_q[1];
        mip_view[11]        = mip_q[2];
        trap_mcause         = '0;
        trap_mcause[XLEN-1] = trap_is_irq_i;
        trap_mcause[4:0]    = trap_cause_i;
    end

    // Legalise the WB write value once; the same value feeds commit and bypass.
    always_comb begin
        wb_ok      = 1'b0;
        wb_val     = wb_csr_wdata_i;
        mtvec_mode = wb_csr_wdata_i[1:0];
        if (mtvec_mode[1] || !MTVEC_VEC_EN) mtvec_mode = 2'b00;
        case (wb_csr_idx_i)
            A_MSTATUS: begin
                wb_ok          = 1'b1;
                wb_val         = '0;
                wb_val[12:11]  = 2'b11;
                wb_val[7]      = wb_csr_wdata_i[7];
                wb_val[3]      = wb_csr_wdata_i[3];
            end
            A_MIE: begin
                wb_ok      = 1'b1;
                wb_val     = '0;
                wb_val[3]  = wb_csr_wdata_i[3];
                wb_val[7]  = wb_csr_wdata_i[7];
                wb_val[11] = wb_csr_wdata_i[11];
            end
            A_MTVEC: begin
                wb_ok       = 1'b1;
                wb_val[1:0] = mtvec_mode;
            end
            A_MEPC: begin
                wb_ok       = 1'b1;
                wb_val[1:0] = 2'b00;
            end
            A_MSCRATCH, A_MCAUSE, A_MTVAL: wb_ok = 1'b1;
            A_MCYCLE, A_MINSTRET:          wb_ok = CNT_EN;
            A_MCYCLEH, A_MINSTRETH:        wb_ok = CNT_EN && (XLEN == 32);
            default: ;
        endcase
    end

    assign wr = wb_csr_wen_i && wb_ok;

    always_comb begin
        ex_csr_rdata_o = '0;
        ex_csr_ill_o   = 1'b0;
        case (ex_csr_idx_i)
            A_MSTATUS:  ex_csr_rdata_o = mstatus_view;
            A_MIE:      ex_csr_rdata_o = mie_view;
            A_MTVEC:    ex_csr_rdata_o = mtvec_q;
            A_MSCRATCH: ex_csr_rdata_o = mscratch_q;
            A_MEPC:     ex_csr_rdata_o = mepc_q;
            A_MCAUSE:   ex_csr_rdata_o = mcause_q;
            A_MTVAL:    ex_csr_rdata_o = mtval_q;
            A_MIP:      ex_csr_rdata_o = mip_view;
            A_MCYCLE:   ex_csr_rdata_o = mcycle_q[XLEN-1:0];
            A_MINSTRET: ex_csr_rdata_o = minstret_q[XLEN-1:0];
            A_MCYCLEH: begin
                if (XLEN == 32) ex_csr_rdata_o = XLEN'(mcycle_q >> 32);
                else            ex_csr_ill_o   = 1'b1;
            end
            A_MINSTRETH: begin
                if (XLEN == 32) ex_csr_rdata_o = XLEN'(minstret_q >> 32);
                else            ex_csr_ill_o   = 1'b1;
            end
            default: ex_csr_ill_o = 1'b1;
        endcase
        if (wr && wb_csr_idx_i == ex_csr_idx_i) ex_csr_rdata_o = wb_val;
    end

    // A write to either half of a counter suppresses that counter's increment.
    always_comb begin
        wdata64    = 64'(wb_csr_wdata_i);
        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = minstret_q + 64'(instret_i);
        if (wr && wb_csr_idx_i == A_MCYCLE)
            mcycle_d = (mcycle_q & ~LO_MASK) | (wdata64 & LO_MASK);
        else if (wr && wb_csr_idx_i == A_MCYCLEH)
            mcycle_d = (mcycle_q & LO_MASK) | (wdata64 << 32);
        if (wr && wb_csr_idx_i == A_MINSTRET)
            minstret_d = (minstret_q & ~LO_MASK) | (wdata64 & LO_MASK);
        else if (wr && wb_csr_idx_i == A_MINSTRETH)
            minstret_d = (minstret_q & LO_MASK) | (wdata64 << 32);
        if (!CNT_EN) begin
            mcycle_d   = '0;
            minstret_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_mie     <= 1'b0;
            st_mpie    <= 1'b0;
            mie_q      <= '0;
            mip_q      <= '0;
            mtvec_q    <= MTVEC_RESET;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mip_q      <= {irq_ext_i, irq_timer_i, irq_sw_i};
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
            if (trap_valid_i) begin
                st_mpie  <= st_mie;
                st_mie   <= 1'b0;
                mepc_q   <= {trap_pc_i[XLEN-1:2], 2'b00};
                mcause_q <= trap_mcause;
                mtval_q  <= trap_is_irq_i ? '0 : trap_tval_i;
            end else begin
                if (mret_i) begin
                    st_mie  <= st_mpie;
                    st_mpie <= 1'b1;
                end else if (wr && wb_csr_idx_i == A_MSTATUS) begin
                    st_mie  <= wb_val[3];
                    st_mpie <= wb_val[7];
                end
                if (wr && wb_csr_idx_i == A_MEPC)   mepc_q   <= wb_val;
                if (wr && wb_csr_idx_i == A_MCAUSE) mcause_q <= wb_val;
                if (wr && wb_csr_idx_i == A_MTVAL)  mtval_q  <= wb_val;
            end
            if (wr && wb_csr_idx_i == A_MIE)
                mie_q <= {wb_val[11], wb_val[7], wb_val[3]};
            if (wr && wb_csr_idx_i == A_MTVEC)    mtvec_q    <= wb_val;
            if (wr && wb_csr_idx_i == A_MSCRATCH) mscratch_q <= wb_val;
        end
    end

    always_comb begin
        base          = {mtvec_q[XLEN-1:2], 2'b00};
        trap_target_o = base;
        if (mtvec_q[1:0] == 2'b01 && trap_is_irq_i)
            trap_target_o = base + (XLEN'(trap_cause_i) << 2);
    end

    assign mepc_rdata_o  = mepc_q;
    assign irq_pending_o = st_mie & |(mip_q & mie_q);

endmodule
